vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
Timing generator for the 640x480@60 Hz VGA pipeline and the source side of the pixel interface. Divides the system clock into a pixel-rate enable and scans raster coordinates. Drives pixel_x, pixel_y, video_on, tick and ref_tick into the pixel generator, and hsync/vsync to the connector. Also counts completed frames for game logic and debug.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
pixel_y  out  10  current vertical count, 0..V_TOTAL-1
video_on  out  1  high when pixel_x<H_DISPLAY and pixel_y<V_DISPLAY
tick  out  1  pixel enable; one clk wide, every CLK_DIV clks
ref_tick  out  1  one clk pulse per frame at start of vertical blanking
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
frame_cnt  out  8  completed-frame counter, wraps 255->0

Behaviour:
- H_TOTAL=H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL=V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525). Both must be <=1024; elaboration error otherwise.
- Divider div, range 0..CLK_DIV-1, increments every clk and wraps to 0. tick = (div==CLK_DIV-1), decoded from the registered div only. With CLK_DIV=1, tick is constantly 1.
- On a clk edge with tick=1:
  - h_count advances; at H_TOTAL-1 it wraps to 0 and v_count advances.
  - v_count wraps from V_TOTAL-1 to 0. On that wrap, frame_cnt increments.
  - Counters hold on all other edges.
- pixel_x=h_count and pixel_y=v_count, both direct register outputs.
- hsync, vsync and video_on are registered from the next-state counter values, so they always correspond exactly to the pixel_x/pixel_y presented in the same cycle. Zero latency relative to the coordinates, glitch-free.
  - hsync=0 iff H_DISPLAY+H_FRONT <= pixel_x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
  - vsync=0 iff V_DISPLAY+V_FRONT <= pixel_y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
- ref_tick is registered. It is 1 for exactly one clk: the cycle in which counters first equal (0,V_DISPLAY), i.e. the edge leaving (H_TOTAL-1,V_DISPLAY-1). It is 0 otherwise, including later clks of that same pixel period. Consumers update game state on it; frame geometry is stable for the whole blanking interval.
- Reset values (asserted asynchronously, held while rst=1):
  - div=0, pixel_x=0, pixel_y=0, frame_cnt=0.
  - video_on=1, hsync=1, vsync=1, ref_tick=0.
  - tick=(CLK_DIV==1).
- Reset mid-frame: all state returns immediately to the reset values. Scanning restarts at (0,0) with a full first pixel period (first tick CLK_DIV clks after rst deassert). No partial sync pulse or ref_tick is emitted.
- No other inputs; free-running. All outputs are stable between ticks except ref_tick.

Test Plan:
- Reset: rst pulse mid-clock -> all outputs at reset values asynchronously; after release, tick first high on the 4th clk and every 4 clks thereafter, period exactly 4.
- Line timing: run one line -> pixel_x 0..799 then 0; video_on high for 640 ticks; hsync low for exactly 96 ticks starting at pixel_x=656; pixel_y increments once, at the 799->0 wrap.
- Frame timing: run 420000 ticks -> pixel_y wraps 524->0, frame_cnt 0->1; vsync low only on lines 490-491 (1600 ticks); video_on never high for pixel_y>=480.
- ref_tick: run 3 frames -> exactly 3 one-clk pulses, each with pixel_x=0, pixel_y=480, spaced 1680000 clks apart.
- Mid-frame reset: assert rst at (700,300) -> immediate return to (0,0), hsync=vsync=1; no ref_tick until pixel_y reaches 480 in the new frame.
- CLK_DIV=1 build: tick constantly 1; a full line takes 800 clks; frame_cnt wraps 255->0 after 256 frames.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// Raster timing generator for a VGA pixel pipeline (defaults: 640x480@60 Hz
// from a 100 MHz system clock).
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   pixel_x    current horizontal count, 0..H_TOTAL-1 (register output)
//   pixel_y    current vertical count, 0..V_TOTAL-1 (register output)
//   video_on   high while (pixel_x, pixel_y) lies in the visible area
//   tick       pixel-rate enable, one clk wide every CLK_DIV clks
//   ref_tick   one-clk pulse when the raster enters vertical blanking
//   hsync      horizontal sync, active-low
//   vsync      vertical sync, active-low
//   frame_cnt  completed-frame counter, wraps 255 -> 0
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       tick,
    output logic       ref_tick,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] V_PRE_BL = 10'(V_DISPLAY - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    // The coordinate outputs are only 10 bits wide.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV must lie in 1..16");
    end

    logic [DIV_W-1:0] div;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic             line_end;
    logic             frame_end;
    logic             ref_next;

    // tick is decoded from the registered divider only, so it is glitch-free.
    // With CLK_DIV=1 the divider is stuck at 0 and tick is constantly 1.
    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Next raster position. Sync/blank flags are derived from these values
    // so that, once registered, they line up with the coordinates they
    // describe in the same cycle.
    always_comb begin
        h_next    = pixel_x;
        v_next    = pixel_y;
        line_end  = tick && (pixel_x == H_LAST);
        frame_end = line_end && (pixel_y == V_LAST);
        ref_next  = line_end && (pixel_y == V_PRE_BL);
        if (tick) begin
            if (line_end) begin
                h_next = '0;
                v_next = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
            end else begin
                h_next = pixel_x + 10'd1;
            end
        end
    end

    // ref_tick is set only on the single edge that enters (0, V_DISPLAY);
    // later clks of that pixel period see no tick and clear it again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_x   <= '0;
            pixel_y   <= '0;
            video_on  <= 1'b1;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            ref_tick  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            pixel_x   <= h_next;
            pixel_y   <= v_next;
            video_on  <= (h_next < H_VIS) && (v_next < V_VIS);
            hsync     <= ~((h_next >= HS_FIRST) && (h_next <= HS_LAST));
            vsync     <= ~((v_next >= VS_FIRST) && (v_next <= VS_LAST));
            ref_tick  <= ref_next;
            if (frame_end) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule
